// File: rtl/encoder_pkg.sv
// Shared widths and types for the registered priority encoder.
// Optional multi-hot error output is enabled with ENC4TO2_ERR_EN.
package encoder_pkg;

    localparam int ENC_W_IN = 4;

    function automatic int enc_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    localparam int ENC_W_OUT = enc_clog2(ENC_W_IN);

    typedef logic [ENC_W_IN-1:0]  enc_in_t;
    typedef logic [ENC_W_OUT-1:0] enc_idx_t;

endpackage

// File: rtl/encoder_4to2_core.sv
// Combinational MSB-first priority scan; produces next-state values for the output bank.
// next_err (multi-hot flag) exists only with ENC4TO2_ERR_EN.
module encoder_4to2_core
    import encoder_pkg::*;
#(
    parameter int W_IN = ENC_W_IN
) (
    input  logic [W_IN-1:0]         in,
    output logic [$clog2(W_IN)-1:0] next_out,
    output logic                    next_valid
`ifdef ENC4TO2_ERR_EN
    ,output logic                   next_err
`endif
);

    localparam int W_OUT = $clog2(W_IN);

    always_comb begin
        logic found;
        found    = 1'b0;
        next_out = '0;
        for (int i = W_IN - 1; i >= 0; i--) begin
            if (!found && in[i]) begin
                next_out = W_OUT'(i);
                found    = 1'b1;
            end
        end
        next_valid = found;
    end

`ifdef ENC4TO2_ERR_EN
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign next_err = |(in & (in - 1'b1));
`endif

endmodule

// File: rtl/encoder_4to2.sv
// Registered priority encoder top: core scan plus one-cycle output register bank.
// Build with ENC4TO2_ERR_EN to add the registered multi-hot err output.
module encoder_4to2
    import encoder_pkg::*;
#(
    parameter int W_IN = ENC_W_IN
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [W_IN-1:0]         in,
    output logic [$clog2(W_IN)-1:0] out,
    output logic                    valid
`ifdef ENC4TO2_ERR_EN
    ,output logic                   err
`endif
);

    localparam int W_OUT = $clog2(W_IN);

    logic [W_OUT-1:0] next_out;
    logic             next_valid;

`ifdef ENC4TO2_ERR_EN
    logic next_err;

    encoder_4to2_core #(.W_IN(W_IN)) u_core (
        .in         (in),
        .next_out   (next_out),
        .next_valid (next_valid),
        .next_err   (next_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= next_err;
    end
`else
    encoder_4to2_core #(.W_IN(W_IN)) u_core (
        .in         (in),
        .next_out   (next_out),
        .next_valid (next_valid)
    );
`endif

    // Core already forces the index to zero on an empty vector, so out is never held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out   <= '0;
            valid <= 1'b0;
        end else begin
            out   <= next_out;
            valid <= next_valid;
        end
    end

endmodule

// File: tb/tb_encoder_4to2.sv
// Scoreboard bench for encoder_4to2 at W_IN=4 and W_IN=8; err checked when ENC4TO2_ERR_EN is set.
module tb_encoder_4to2;

    typedef struct {
        int idx;
        bit vld;
        bit err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = 4'b0;
    logic [7:0] din8 = 8'b0;
    logic [1:0] out4;
    logic [2:0] out8;
    logic       valid4, valid8;
`ifdef ENC4TO2_ERR_EN
    logic       err4, err8;
`endif

    int n_chk = 0;
    int n_fail = 0;
    exp_t q4[$];
    exp_t q8[$];

    always #5 clk = ~clk;

`ifdef ENC4TO2_ERR_EN
    encoder_4to2 #(.W_IN(4)) dut (.clk(clk), .rst_n(rst_n), .in(din),  .out(out4), .valid(valid4), .err(err4));
    encoder_4to2 #(.W_IN(8)) dut8 (.clk(clk), .rst_n(rst_n), .in(din8), .out(out8), .valid(valid8), .err(err8));
`else
    encoder_4to2 #(.W_IN(4)) dut (.clk(clk), .rst_n(rst_n), .in(din),  .out(out4), .valid(valid4));
    encoder_4to2 #(.W_IN(8)) dut8 (.clk(clk), .rst_n(rst_n), .in(din8), .out(out8), .valid(valid8));
`endif

    // Reference: index of highest set bit by repeated halving; err from popcount.
    function automatic exp_t model(input int unsigned v);
        exp_t e;
        int unsigned t;
        e.idx = 0;
        t = v;
        while (t > 1) begin
            t = t >> 1;
            e.idx++;
        end
        e.vld = (v != 0);
        e.err = ($countones(v) > 1);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] b);
        @(negedge clk);
        din  = a;
        din8 = b;
        q4.push_back(model(a));
        q8.push_back(model(b));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out4"},   int'(out4),   0);
        check({tag, "_valid4"}, int'(valid4), 0);
        check({tag, "_out8"},   int'(out8),   0);
        check({tag, "_valid8"}, int'(valid8), 0);
`ifdef ENC4TO2_ERR_EN
        check({tag, "_err4"},   int'(err4),   0);
        check({tag, "_err8"},   int'(err8),   0);
`endif
    endtask

    // Monitor: each rising edge with reset released presents one result per queued vector.
    exp_t e4, e8;
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n && q4.size() > 0) begin
            e4 = q4.pop_front();
            check("out4",   int'(out4),   e4.idx);
            check("valid4", int'(valid4), int'(e4.vld));
`ifdef ENC4TO2_ERR_EN
            check("err4",   int'(err4),   int'(e4.err));
`endif
        end
        if (rst_n && q8.size() > 0) begin
            e8 = q8.pop_front();
            check("out8",   int'(out8),   e8.idx);
            check("valid8", int'(valid8), int'(e8.vld));
`ifdef ENC4TO2_ERR_EN
            check("err8",   int'(err8),   int'(e8.err));
`endif
        end
    end

    initial begin
        logic [3:0] sweep [5];
        sweep = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

        // Reset held with active requests: outputs stay cleared across edges.
        din  = 4'b1000;
        din8 = 8'h80;
        repeat (3) begin
            @(negedge clk);
            check_cleared("rst_hold");
        end
        rst_n = 1'b1;
        q4.push_back(model(din));
        q8.push_back(model(din8));

        foreach (sweep[i]) drive(sweep[i], 8'(sweep[i]));

        drive(4'b1010, 8'h90);
        drive(4'b0110, 8'h00);
        drive(4'b1111, 8'hff);

        drive(4'b1000, 8'h01);
        drive(4'b0000, 8'h00);
        drive(4'b0001, 8'h40);

        for (int k = 0; k < 40; k++) drive(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));

        // Mid-stream async reset while valid is high.
        drive(4'b1000, 8'h90);
        @(posedge clk);
        #3;
        check("pre_rst_valid4", int'(valid4), 1);
        check("pre_rst_valid8", int'(valid8), 1);
        rst_n = 1'b0;
        #1;
        check_cleared("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        q4.push_back(model(din));
        q8.push_back(model(din8));

        for (int k = 0; k < 10; k++) drive(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));

        for (int k = 0; k < 10 && (q4.size() > 0 || q8.size() > 0); k++) @(negedge clk);
        check("drain_q4", q4.size(), 0);
        check("drain_q8", q8.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
